// File: rtl/legv8_pkg.sv
// rtl/legv8_pkg.sv - shared opcodes, ALU function codes and sequencer state types
package legv8_pkg;

    typedef enum logic [2:0] {
        CLR    = 3'd0,
        IDLE   = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        FMT_R       = 3'd0,
        FMT_I       = 3'd1,
        FMT_LDUR    = 3'd2,
        FMT_STUR    = 3'd3,
        FMT_ILLEGAL = 3'd4
    } fmt_t;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_ADDS = 11'b10101011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_SUBS = 11'b11101011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [9:0]  OP_ADDI = 10'b1001000100;
    localparam logic [9:0]  OP_SUBI = 10'b1101000100;

    localparam logic [4:0] FS_AND = 5'b00000;
    localparam logic [4:0] FS_ORR = 5'b00100;
    localparam logic [4:0] FS_ADD = 5'b01000;
    localparam logic [4:0] FS_SUB = 5'b01001;

endpackage

// File: rtl/instr_decoder.sv
// rtl/instr_decoder.sv - combinational opcode classification, field extraction and immediate extension
module instr_decoder
    import legv8_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [31:0]       i_instr,
    output fmt_t              o_fmt,
    output logic [4:0]        o_fs,
    output logic [4:0]        o_rd,
    output logic [4:0]        o_rn,
    output logic [4:0]        o_rm,
    output logic              o_set_flags,
    output logic [DATA_W-1:0] o_k
);

    logic [10:0]       w_op11;
    logic [9:0]        w_op10;
    logic [DATA_W-1:0] w_imm12;
    logic [DATA_W-1:0] w_imm9;

    assign w_op11  = i_instr[31:21];
    assign w_op10  = i_instr[31:22];
    assign o_rd    = i_instr[4:0];
    assign o_rn    = i_instr[9:5];
    assign o_rm    = i_instr[20:16];
    assign w_imm12 = {{(DATA_W-12){1'b0}}, i_instr[21:10]};
    assign w_imm9  = {{(DATA_W-9){i_instr[20]}}, i_instr[20:12]};

    // Classify the opcode; 10-bit I-type opcodes never collide with the 11-bit ones
    always_comb begin
        o_fmt       = FMT_ILLEGAL;
        o_fs        = FS_ADD;
        o_set_flags = 1'b0;
        o_k         = '0;
        case (w_op11)
            OP_ADD:  o_fmt = FMT_R;
            OP_ADDS: begin o_fmt = FMT_R; o_set_flags = 1'b1; end
            OP_SUB:  begin o_fmt = FMT_R; o_fs = FS_SUB; end
            OP_SUBS: begin o_fmt = FMT_R; o_fs = FS_SUB; o_set_flags = 1'b1; end
            OP_AND:  begin o_fmt = FMT_R; o_fs = FS_AND; end
            OP_ORR:  begin o_fmt = FMT_R; o_fs = FS_ORR; end
            OP_LDUR: begin o_fmt = FMT_LDUR; o_k = w_imm9; end
            OP_STUR: begin o_fmt = FMT_STUR; o_k = w_imm9; end
            default: begin
                if (w_op10 == OP_ADDI) begin
                    o_fmt = FMT_I;
                    o_k   = w_imm12;
                end else if (w_op10 == OP_SUBI) begin
                    o_fmt = FMT_I;
                    o_fs  = FS_SUB;
                    o_k   = w_imm12;
                end
            end
        endcase
    end

endmodule

// File: rtl/datapath_sequencer.sv
// rtl/datapath_sequencer.sv - LEGv8 instruction sequencer driving register file, ALU and RAM controls
module datapath_sequencer
    import legv8_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              instr_valid,
    input  logic [31:0]       instr,
    output logic              instr_ready,
    input  logic [3:0]        status,
    output logic [4:0]        DA,
    output logic [4:0]        SA,
    output logic [4:0]        SB,
    output logic [4:0]        FS,
    output logic [DATA_W-1:0] k,
    output logic              Bsel,
    output logic              dataMux,
    output logic              regW,
    output logic              ramW,
    output logic              R,
    output logic              done,
    output logic              illegal,
    output logic [3:0]        flags
);

    state_t            r_state;
    state_t            w_next;
    logic [31:0]       r_instr;
    logic [3:0]        r_flags;
    fmt_t              w_fmt;
    logic [4:0]        w_fs;
    logic [4:0]        w_rd;
    logic [4:0]        w_rn;
    logic [4:0]        w_rm;
    logic              w_set_flags;
    logic [DATA_W-1:0] w_k;

    instr_decoder #(.DATA_W(DATA_W)) u_decoder (
        .i_instr     (r_instr),
        .o_fmt       (w_fmt),
        .o_fs        (w_fs),
        .o_rd        (w_rd),
        .o_rn        (w_rn),
        .o_rm        (w_rm),
        .o_set_flags (w_set_flags),
        .o_k         (w_k)
    );

    assign flags = r_flags;

    // State, captured instruction and flag registers; reset wins over everything
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= CLR;
            r_instr <= '0;
            r_flags <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && instr_valid) begin
                r_instr <= instr;
            end
            if (r_state == EXEC && w_set_flags) begin
                r_flags <= status;
            end
        end
    end

    // Next state and per-state control outputs; writes are suppressed while reset is high
    always_comb begin
        w_next      = r_state;
        instr_ready = 1'b0;
        DA          = '0;
        SA          = '0;
        SB          = '0;
        FS          = '0;
        k           = '0;
        Bsel        = 1'b0;
        dataMux     = 1'b0;
        regW        = 1'b0;
        ramW        = 1'b0;
        R           = 1'b0;
        done        = 1'b0;
        illegal     = 1'b0;
        case (r_state)
            CLR: begin
                R      = 1'b1;
                w_next = IDLE;
            end
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) w_next = DECODE;
            end
            DECODE: begin
                if (w_fmt == FMT_ILLEGAL) begin
                    illegal = 1'b1;
                    w_next  = IDLE;
                end else begin
                    w_next = EXEC;
                end
            end
            EXEC: begin
                w_next = IDLE;
                SA     = w_rn;
                FS     = w_fs;
                k      = w_k;
                case (w_fmt)
                    FMT_R: begin
                        SB   = w_rm;
                        Bsel = 1'b1;
                        k    = '0;
                        DA   = w_rd;
                        regW = 1'b1;
                        done = 1'b1;
                    end
                    FMT_I: begin
                        DA   = w_rd;
                        regW = 1'b1;
                        done = 1'b1;
                    end
                    FMT_LDUR: begin
                        FS     = FS_ADD;
                        w_next = MEM;
                    end
                    FMT_STUR: begin
                        SB   = w_rd;
                        FS   = FS_ADD;
                        ramW = 1'b1;
                        done = 1'b1;
                    end
                    default: begin
                        SA = '0;
                        FS = '0;
                        k  = '0;
                    end
                endcase
            end
            MEM: begin
                SA      = w_rn;
                k       = w_k;
                FS      = FS_ADD;
                DA      = w_rd;
                dataMux = 1'b1;
                regW    = 1'b1;
                done    = 1'b1;
                w_next  = IDLE;
            end
            default: w_next = CLR;
        endcase
        if (reset) begin
            regW = 1'b0;
            ramW = 1'b0;
        end
    end

endmodule

// File: tb/tb_datapath_sequencer.sv
// tb/tb_datapath_sequencer.sv - directed self-checking bench for datapath_sequencer
module tb_datapath_sequencer;

    logic        clock;
    logic        reset;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic [3:0]  status;
    logic [4:0]  DA, SA, SB, FS;
    logic [63:0] k;
    logic        Bsel, dataMux, regW, ramW, R, done, illegal;
    logic [3:0]  flags;

    int n_checks = 0;
    int n_fail   = 0;

    datapath_sequencer #(.DATA_W(64)) dut (
        .clock       (clock),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .status      (status),
        .DA          (DA),
        .SA          (SA),
        .SB          (SB),
        .FS          (FS),
        .k           (k),
        .Bsel        (Bsel),
        .dataMux     (dataMux),
        .regW        (regW),
        .ramW        (ramW),
        .R           (R),
        .done        (done),
        .illegal     (illegal),
        .flags       (flags)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one instruction in IDLE and advance through the handshake edge into DECODE
    task automatic issue(input logic [31:0] word);
        chk("ready_before_issue", 64'(instr_ready), 64'd1);
        instr_valid = 1'b1;
        instr       = word;
        step();
        instr_valid = 1'b0;
        instr       = 32'h8B020023;
    endtask

    initial begin
        clock       = 1'b0;
        reset       = 1'b1;
        instr_valid = 1'b0;
        instr       = '0;
        status      = '0;
        step();
        step();
        chk("rst_R", 64'(R), 64'd1);
        chk("rst_ready", 64'(instr_ready), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_illegal", 64'(illegal), 64'd0);
        chk("rst_flags", 64'(flags), 64'd0);
        chk("rst_regW", 64'(regW), 64'd0);
        reset = 1'b0;
        step();
        chk("idle_ready", 64'(instr_ready), 64'd1);
        chk("idle_R", 64'(R), 64'd0);

        // ADD X3,X1,X2
        issue(32'h8B020023);
        chk("add_dec_ready", 64'(instr_ready), 64'd0);
        chk("add_dec_regW", 64'(regW), 64'd0);
        chk("add_dec_done", 64'(done), 64'd0);
        chk("add_dec_SA", 64'(SA), 64'd0);
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        chk("add_SA", 64'(SA), 64'd1);
        chk("add_SB", 64'(SB), 64'd2);
        chk("add_DA", 64'(DA), 64'd3);
        chk("add_Bsel", 64'(Bsel), 64'd1);
        chk("add_FS", 64'(FS), 64'h08);
        chk("add_regW", 64'(regW), 64'd1);
        chk("add_dataMux", 64'(dataMux), 64'd0);
        chk("add_done", 64'(done), 64'd1);
        step();
        chk("add_back_idle", 64'(instr_ready), 64'd1);
        chk("add_done_pulse", 64'(done), 64'd0);

        // ADDS X1,X2,X3 latches status at the end of EXEC
        issue(32'hAB030041);
        step();
        status = 4'b1010;
        chk("adds_FS", 64'(FS), 64'h08);
        chk("adds_done", 64'(done), 64'd1);
        chk("adds_flags_before", 64'(flags), 64'd0);
        step();
        chk("adds_flags", 64'(flags), 64'hA);

        // ADDI X5,X4,#100 must not touch flags
        issue(32'h91019085);
        step();
        status = 4'b0101;
        chk("addi_k", k, 64'd100);
        chk("addi_Bsel", 64'(Bsel), 64'd0);
        chk("addi_SA", 64'(SA), 64'd4);
        chk("addi_DA", 64'(DA), 64'd5);
        chk("addi_regW", 64'(regW), 64'd1);
        chk("addi_done", 64'(done), 64'd1);
        step();
        chk("addi_flags_held", 64'(flags), 64'hA);

        // AND X4,X5,X6
        issue(32'h8A0600A4);
        step();
        chk("and_FS", 64'(FS), 64'h00);
        chk("and_SA", 64'(SA), 64'd5);
        chk("and_SB", 64'(SB), 64'd6);
        chk("and_DA", 64'(DA), 64'd4);
        step();

        // LDUR X7,[X6,#-8]
        issue(32'hF85F80C7);
        step();
        chk("ldur_exec_k", k, 64'hFFFFFFFFFFFFFFF8);
        chk("ldur_exec_SA", 64'(SA), 64'd6);
        chk("ldur_exec_Bsel", 64'(Bsel), 64'd0);
        chk("ldur_exec_FS", 64'(FS), 64'h08);
        chk("ldur_exec_regW", 64'(regW), 64'd0);
        chk("ldur_exec_done", 64'(done), 64'd0);
        step();
        chk("ldur_mem_DA", 64'(DA), 64'd7);
        chk("ldur_mem_dataMux", 64'(dataMux), 64'd1);
        chk("ldur_mem_regW", 64'(regW), 64'd1);
        chk("ldur_mem_k", k, 64'hFFFFFFFFFFFFFFF8);
        chk("ldur_mem_done", 64'(done), 64'd1);
        step();
        chk("ldur_back_idle", 64'(instr_ready), 64'd1);

        // STUR X9,[X2,#16]
        issue(32'hF8010049);
        step();
        chk("stur_SA", 64'(SA), 64'd2);
        chk("stur_SB", 64'(SB), 64'd9);
        chk("stur_k", k, 64'd16);
        chk("stur_ramW", 64'(ramW), 64'd1);
        chk("stur_regW", 64'(regW), 64'd0);
        chk("stur_Bsel", 64'(Bsel), 64'd0);
        chk("stur_done", 64'(done), 64'd1);
        step();
        chk("stur_ramW_off", 64'(ramW), 64'd0);

        // Undecodable word 0x00000000
        issue(32'h00000000);
        chk("ill_pulse", 64'(illegal), 64'd1);
        chk("ill_regW", 64'(regW), 64'd0);
        chk("ill_ramW", 64'(ramW), 64'd0);
        chk("ill_done", 64'(done), 64'd0);
        step();
        chk("ill_ready", 64'(instr_ready), 64'd1);
        chk("ill_clear", 64'(illegal), 64'd0);

        // Reset during LDUR EXEC aborts before MEM
        issue(32'hF85F80C7);
        step();
        chk("rldur_exec_regW", 64'(regW), 64'd0);
        reset = 1'b1;
        step();
        chk("rldur_R", 64'(R), 64'd1);
        chk("rldur_regW", 64'(regW), 64'd0);
        chk("rldur_dataMux", 64'(dataMux), 64'd0);
        chk("rldur_flags", 64'(flags), 64'd0);
        chk("rldur_ready", 64'(instr_ready), 64'd0);
        reset = 1'b0;
        step();
        chk("rldur_idle_ready", 64'(instr_ready), 64'd1);
        chk("rldur_idle_regW", 64'(regW), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
